// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: 2-FF input synchronizer, mid-bit sampling FSM, and a one-entry
// holding register with VALID/READ handshake plus framing-error and overrun pulses.
module uart_rx_ctrl #(
  parameter int unsigned BIT_TMR_MAX = 10416,
  parameter int unsigned TMR_WIDTH   = 14
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       UART_RX,
  input  logic       READ,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       BUSY
);

  localparam logic [TMR_WIDTH-1:0] TMR_HALF = TMR_WIDTH'(BIT_TMR_MAX / 2 - 1);
  localparam logic [TMR_WIDTH-1:0] TMR_FULL = TMR_WIDTH'(BIT_TMR_MAX - 1);
  localparam logic [TMR_WIDTH-1:0] TMR_ONE  = TMR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_e;

  logic                 rx_meta_q, rx_s_q;
  state_e               state_q, state_d;
  logic [TMR_WIDTH-1:0] tmr_q, tmr_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shreg_q, shreg_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q;
  logic                 deliver;

  // Both sync stages reset high so a reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= UART_RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TMR_ONE;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ferr_d  = 1'b0;
    deliver = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          tmr_d   = '0;
        end
      end
      S_START: begin
        // Half a bit in: a high line here was a glitch, not a start bit.
        if (tmr_q == TMR_HALF) begin
          tmr_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (tmr_q == TMR_FULL) begin
          tmr_d          = '0;
          shreg_d[bit_q] = rx_s_q;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (tmr_q == TMR_FULL) begin
          tmr_d = '0;
          if (rx_s_q) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        // Hold off until the line idles so a break is not seen as repeated 0x00.
        if (rx_s_q) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (deliver) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
      ovr_d   = valid_q && !READ;
    end else if (READ) begin
      valid_d = 1'b0;
    end
  end

  assign DATA      = data_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = ferr_q;
  assign OVERRUN   = ovr_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 16 clocks per bit; every expected value is hand-derived.
module tb_uart_rx_ctrl;
  localparam int BT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rd  = 1'b0;
  logic [7:0] data;
  logic       valid, ferr, ovr, busy;

  int checks = 0;
  int fails  = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int ferr_base, ovr_base, vlow;

  uart_rx_ctrl #(.BIT_TMR_MAX(BT), .TMR_WIDTH(5)) dut (
    .CLK(clk), .RST(rst), .UART_RX(rx), .READ(rd),
    .DATA(data), .VALID(valid), .FRAME_ERR(ferr), .OVERRUN(ovr), .BUSY(busy)
  );

  always #5 clk = ~clk;

  // Pulse cycles are counted on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (ferr) ferr_cnt++;
    if (ovr)  ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the stop bit time.
  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (BT) @(posedge clk);
      #1;
    end
  endtask

  task automatic rd_pulse();
    rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(3);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);
    rst = 1'b0;
    idle(2);

    // 0x41: VALID rises 155 edges after the start-bit drive.
    ferr_base = ferr_cnt; ovr_base = ovr_cnt;
    fork
      send_byte(8'h41, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 chk("lat_pre_valid", valid, 0);
        @(posedge clk);
        #1 chk("lat_valid", valid, 1);
        chk("lat_data", data, 8'h41);
      end
    join
    vlow = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!valid) vlow++;
    end
    @(posedge clk); #1;
    chk("t1_hold_valid_low_cycles", vlow, 0);
    chk("t1_no_ferr", ferr_cnt - ferr_base, 0);
    chk("t1_no_ovr", ovr_cnt - ovr_base, 0);
    rd_pulse();
    chk("t1_read_valid", valid, 0);
    chk("t1_read_data", data, 8'h41);

    // 5-cycle glitch: START aborts at the half-bit check.
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("t2_busy_start", busy, 1);
    repeat (2) @(posedge clk);
    #1 rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("t2_busy_before_abort", busy, 1);
    @(posedge clk);
    #1 chk("t2_busy_abort", busy, 0);
    chk("t2_valid", valid, 0);
    idle(5);
    send_byte(8'h0D, 1'b1);
    chk("t2_data", data, 8'h0D);
    chk("t2_valid_after", valid, 1);
    rd_pulse();

    // 0x55 with low stop bit, then a break.
    ferr_base = ferr_cnt;
    send_byte(8'h55, 1'b0);
    chk("t3_ferr_once", ferr_cnt - ferr_base, 1);
    chk("t3_valid", valid, 0);
    chk("t3_data_kept", data, 8'h0D);
    chk("t3_busy_wait", busy, 1);
    idle(3 * BT);
    chk("t3_busy_break", busy, 1);
    rx = 1'b1;
    idle(4);
    chk("t3_busy_idle", busy, 0);
    chk("t3_ferr_total", ferr_cnt - ferr_base, 1);
    send_byte(8'h0A, 1'b1);
    chk("t3_data_0a", data, 8'h0A);
    chk("t3_valid_0a", valid, 1);
    rd_pulse();
    idle(4);

    // Back-to-back, no READ: one overrun.
    ovr_base = ovr_cnt;
    send_byte(8'h0A, 1'b1);
    chk("t4_ovr_first", ovr_cnt - ovr_base, 0);
    send_byte(8'h0D, 1'b1);
    chk("t4_ovr_once", ovr_cnt - ovr_base, 1);
    chk("t4_data", data, 8'h0D);
    chk("t4_valid", valid, 1);
    rd_pulse();
    idle(4);

    // READ coincides with delivery of 0x0D: no overrun.
    send_byte(8'h0A, 1'b1);
    chk("t5_valid_held", valid, 1);
    ovr_base = ovr_cnt;
    fork
      send_byte(8'h0D, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
      end
    join
    chk("t5_data", data, 8'h0D);
    chk("t5_valid", valid, 1);
    chk("t5_no_ovr", ovr_cnt - ovr_base, 0);
    idle(4);

    // Reset mid-frame at data bit 4 of 0xFF.
    ferr_base = ferr_cnt; ovr_base = ovr_cnt;
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (10 + BT * 4 + 8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("t6_data", data, 8'h00);
        chk("t6_valid", valid, 0);
        chk("t6_busy", busy, 0);
      end
    join
    idle(4);
    chk("t6_busy_after", busy, 0);
    chk("t6_valid_after", valid, 0);
    chk("t6_no_ferr", ferr_cnt - ferr_base, 0);
    chk("t6_no_ovr", ovr_cnt - ovr_base, 0);
    send_byte(8'h42, 1'b1);
    chk("t6_data_42", data, 8'h42);
    chk("t6_valid_42", valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- 8N1 UART receiver that pairs with the existing UART_TX_CTRL on the serial link. It lets the GPIO demo accept host keystrokes in addition to sending text.
- Oversamples UART_RX with the system clock, validates the start bit, samples each bit at mid-bit, and checks the stop bit.
- Received bytes go into a one-entry holding register with a VALID/READ handshake.
- Framing errors and overruns are flagged.

Parameters:
- BIT_TMR_MAX, 10416, clocks per bit (100 MHz / 9600 baud); must be ≥ 4.
- TMR_WIDTH, 14, bit-timer width; must satisfy 2^TMR_WIDTH > BIT_TMR_MAX.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- UART_RX  in  1  asynchronous serial input; idle high.
- READ  in  1  one-cycle pulse; consumes the held byte.
- DATA  out  8  last received byte.
- VALID  out  1  level; high while DATA holds an unread byte.
- FRAME_ERR  out  1  one-cycle pulse when a stop bit is sampled low.
- OVERRUN  out  1  one-cycle pulse when an unread byte is overwritten.
- BUSY  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Input sync: UART_RX passes through a 2-FF synchronizer; both flops reset to 1. rx_s is the second-stage output. All decisions use rx_s, which adds 2 cycles of latency.
- Reset values: DATA = 0x00, VALID = 0, FRAME_ERR = 0, OVERRUN = 0, BUSY = 0, FSM = IDLE, timer = 0, bit index = 0.
- RST dominates everything. Asserting RST mid-frame discards the partial byte and any held byte.
- Bit timer: cleared on every state entry, otherwise increments by 1 each cycle.
- FSM states and transitions:
  - IDLE: when rx_s == 0, go to START with timer = 0.
  - START: when timer == BIT_TMR_MAX/2 − 1 (integer divide), sample rx_s.
    - rx_s == 1: glitch, return to IDLE; nothing else changes.
    - rx_s == 0: go to DATA with bit index = 0.
  - DATA: when timer == BIT_TMR_MAX − 1, sample rx_s into the shift register, LSB first (bit index n → shreg[n]), and clear the timer.
    - After bit index 7 is sampled, go to STOP.
  - STOP: when timer == BIT_TMR_MAX − 1, sample rx_s.
    - rx_s == 1: byte delivery on the next edge (see Holding register); return to IDLE.
    - rx_s == 0: FRAME_ERR = 1 for exactly one cycle; byte discarded; DATA and VALID unchanged; go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s == 1, then go to IDLE. This prevents a break condition from being read as repeated 0x00 frames.
  - Any other (illegal) state encoding → IDLE.
- Holding register:
  - On delivery, DATA ← shreg and VALID ← 1 on the cycle after the stop-bit sample.
  - OVERRUN pulses for one cycle if VALID was already 1 and READ is not asserted in the delivery cycle. The new byte overwrites DATA and VALID stays 1.
  - READ together with delivery: old byte consumed, new byte loaded, VALID stays 1, no OVERRUN.
  - READ with no delivery: VALID ← 0 next cycle; DATA holds its value.
  - READ while VALID = 0: ignored.
- Back-to-back frames: a start bit is detected in the cycle after the FSM returns to IDLE. Zero-length gaps are therefore received correctly at baud tolerance ±2%.
- Latency: from the falling edge of the start bit on UART_RX to VALID = 1 is 2 + (BIT_TMR_MAX/2) + 9·BIT_TMR_MAX + 1 cycles, ±1 cycle of sampling phase.
- BUSY = (state != IDLE). It is a registered output.

Test Plan (BIT_TMR_MAX = 16, so the half-bit sample is at timer = 7):
- 0x41 framed correctly, READ held low → VALID rises at the latency above; DATA = 0x41; no FRAME_ERR/OVERRUN; VALID stays 1 for 100 cycles. READ pulse → VALID = 0 next cycle, DATA stays 0x41.
- UART_RX low for 5 cycles, then high → START aborts; BUSY returns to 0 about 10 cycles after the synchronized falling edge (within 1 cycle); VALID never asserts; a following 0x0D frame is received correctly.
- 0x55 frame with the stop bit driven low, then held low for 3 bit times, then high → exactly one FRAME_ERR pulse; VALID = 0; FSM in WAIT_HIGH until line high. A following 0x0A frame gives DATA = 0x0A.
- Frames 0x0A then 0x0D back-to-back, no READ → exactly one OVERRUN pulse on delivery of 0x0D; DATA = 0x0D; VALID = 1.
- 0x0A held, READ pulsed in the exact delivery cycle of 0x0D → DATA = 0x0D, VALID = 1, OVERRUN = 0.
- RST pulsed at data bit 4 of 0xFF → DATA = 0x00, VALID = 0, BUSY = 0 next cycle, no pulses. A subsequent 0x42 frame gives DATA = 0x42.
